// File: rtl/chip8_display_pkg.sv
// chip8_display_pkg: shared geometry constants and renderer state encoding
// for the CHIP-8 display to LCD framebuffer upscaler.
package chip8_display_pkg;
    localparam int CHIP8_W           = 64;
    localparam int CHIP8_H           = 32;
    localparam int SRC_BYTES         = 256;
    localparam int LCD_BYTES_PER_ROW = 16;
    localparam int FB_BYTES          = 1024;
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, W0, W1, W2, W3, DONE} state_e;
endpackage

// File: rtl/nibble_doubler.sv
// nibble_doubler: stretches a 4-pixel nibble to 8 pixels by repeating each bit, MSB first.
module nibble_doubler (
    input  logic [3:0] nib,
    output logic [7:0] dbl
);
    assign dbl = {nib[3], nib[3], nib[2], nib[2], nib[1], nib[1], nib[0], nib[0]};
endmodule

// File: rtl/fb_upscale_renderer.sv
// fb_upscale_renderer: copies the 64x32 CHIP-8 display from main RAM into the
// 128x64 LCD framebuffer, doubling every pixel horizontally and vertically.
module fb_upscale_renderer
    import chip8_display_pkg::*;
#(
    parameter logic [11:0] SRC_BASE = 12'hF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_signal,
    output logic [11:0] main_ram_read_address,
    input  logic [7:0]  main_ram_out,
    output logic [9:0]  fb_write_address,
    output logic        fb_write_enable,
    output logic [7:0]  fb_ram_in,
    output logic        busy,
    output logic        finished_signal
);
    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  hi_dbl, lo_dbl;
    logic        odd_row, odd_col;

    nibble_doubler u_hi (.nib(data_q[7:4]), .dbl(hi_dbl));
    nibble_doubler u_lo (.nib(data_q[3:0]), .dbl(lo_dbl));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start_signal) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                data_d  = main_ram_out;
                state_d = W0;
            end
            W0: state_d = W1;
            W1: state_d = W2;
            W2: state_d = W3;
            W3: begin
                if (idx_q == 8'(SRC_BYTES - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Framebuffer address = {row, byte-in-row, half}: row = 2y+odd_row, byte = 2xb+odd_col.
    assign odd_row               = (state_q == W2) || (state_q == W3);
    assign odd_col               = (state_q == W1) || (state_q == W3);
    assign fb_write_enable       = (state_q == W0) || (state_q == W1) || odd_row;
    assign fb_write_address      = fb_write_enable ? {idx_q[7:3], odd_row, idx_q[2:0], odd_col} : '0;
    assign fb_ram_in             = !fb_write_enable ? '0 : odd_col ? lo_dbl : hi_dbl;
    assign main_ram_read_address = SRC_BASE + {4'd0, idx_q};
    assign busy                  = state_q != IDLE;
    assign finished_signal       = state_q == DONE;
endmodule

// File: tb/tb_fb_upscale_renderer.sv
// tb_fb_upscale_renderer: scoreboard bench for the framebuffer upscaler, with a
// second instance whose source window straddles the top of main RAM.
module tb_fb_upscale_renderer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_signal = 1'b0;
    logic [11:0] rd1, rd2;
    logic [7:0]  ram_out1, ram_out2, fd1, fd2;
    logic [9:0]  fa1, fa2;
    logic        we1, we2, busy1, busy2, fin1, fin2;
    logic [7:0]  ram [4096];

    typedef struct {
        logic [9:0]  fa;
        logic [7:0]  fd;
        logic [11:0] ra;
    } wr_t;
    wr_t q1[$], q2[$];
    wr_t e1, e2;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int wcnt1 = 0, dup1 = 0, fcnt1 = 0, fcyc1 = -1, fcnt2 = 0;
    bit seen1 [1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        ram_out1 <= ram[rd1];
        ram_out2 <= ram[rd2];
    end

    fb_upscale_renderer u_dut (
        .clk(clk), .reset(reset), .start_signal(start_signal),
        .main_ram_read_address(rd1), .main_ram_out(ram_out1),
        .fb_write_address(fa1), .fb_write_enable(we1), .fb_ram_in(fd1),
        .busy(busy1), .finished_signal(fin1)
    );

    fb_upscale_renderer #(.SRC_BASE(12'hFF8)) u_wrap (
        .clk(clk), .reset(reset), .start_signal(start_signal),
        .main_ram_read_address(rd2), .main_ram_out(ram_out2),
        .fb_write_address(fa2), .fb_write_enable(we2), .fb_ram_in(fd2),
        .busy(busy2), .finished_signal(fin2)
    );

    function automatic logic [7:0] dbl(input logic [3:0] n);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r[2*i]   = n[i];
            r[2*i+1] = n[i];
        end
        return r;
    endfunction

    // Expected writes for a whole frame, in the order the renderer must emit them.
    task automatic push_frame(input logic [11:0] base, input int which);
        wr_t w;
        logic [7:0] b;
        int row, col;
        for (int i = 0; i < 256; i++) begin
            w.ra = base + 12'(i);
            b    = ram[w.ra];
            row  = 2 * (i / 8);
            col  = 2 * (i % 8);
            for (int j = 0; j < 4; j++) begin
                w.fa = 10'((row + j / 2) * 16 + col + j % 2);
                w.fd = (j % 2) ? dbl(b[3:0]) : dbl(b[7:4]);
                if (which == 1) q1.push_back(w);
                else q2.push_back(w);
            end
        end
    endtask

    task automatic clear_stats();
        wcnt1 = 0; dup1 = 0; fcnt1 = 0; fcyc1 = -1; fcnt2 = 0;
        foreach (seen1[i]) seen1[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (we1) begin
            wcnt1++;
            if (seen1[fa1]) dup1++;
            seen1[fa1] = 1'b1;
            n_cmp++;
            if (q1.size() == 0) begin
                n_bad++;
                $display("FAIL write1_unexpected got addr=%0d data=%h", fa1, fd1);
            end else begin
                e1 = q1.pop_front();
                if ({fa1, fd1, rd1} !== {e1.fa, e1.fd, e1.ra}) begin
                    n_bad++;
                    $display("FAIL write1 got addr=%0d data=%h src=%h exp addr=%0d data=%h src=%h",
                             fa1, fd1, rd1, e1.fa, e1.fd, e1.ra);
                end
            end
        end
        if (we2) begin
            n_cmp++;
            if (q2.size() == 0) begin
                n_bad++;
                $display("FAIL write2_unexpected got addr=%0d data=%h", fa2, fd2);
            end else begin
                e2 = q2.pop_front();
                if ({fa2, fd2, rd2} !== {e2.fa, e2.fd, e2.ra}) begin
                    n_bad++;
                    $display("FAIL write2 got addr=%0d data=%h src=%h exp addr=%0d data=%h src=%h",
                             fa2, fd2, rd2, e2.fa, e2.fd, e2.ra);
                end
            end
        end
        if (fin1) begin
            fcnt1++;
            fcyc1 = cyc;
        end
        if (fin2) fcnt2++;
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if ({we1, fin1, busy1, fa1, fd1, rd1} !== {1'b0, 1'b0, 1'b0, 10'd0, 8'd0, 12'hF00}) begin
            n_bad++;
            $display("FAIL reset_state got we=%b fin=%b busy=%b addr=%0d data=%h src=%h exp 0 0 0 0 00 f00",
                     we1, fin1, busy1, fa1, fd1, rd1);
        end
        n_cmp++;
        if (rd2 !== 12'hFF8) begin
            n_bad++;
            $display("FAIL reset_src_wrap got=%h exp=ff8", rd2);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_frame();
        int t0;
        logic [9:0] ea;
        logic [7:0] ed;
        clear_stats();
        ram[12'hF00] = 8'hA5;
        ram[12'hF09] = 8'hF0;
        ram[12'hFFF] = 8'h81;
        push_frame(12'hF00, 1);
        push_frame(12'hFF8, 2);
        @(posedge clk); #1;
        start_signal = 1'b1;
        t0 = cyc;
        @(negedge clk); #1;
        n_cmp++;
        if (busy1 !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_cycle0 got=%b exp=0", busy1);
        end
        for (int k = 1; k <= 1540; k++) begin
            @(posedge clk); #1;
            start_signal = 1'b0;
            @(negedge clk); #1;
            if (k == 1) begin
                n_cmp++;
                if (busy1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_rise got=%b exp=1", busy1);
                end
            end
            if ((k >= 3 && k <= 6) || (k >= 57 && k <= 60) || (k >= 1533 && k <= 1536)) begin
                ea = (k <= 6) ? 10'(k == 3 ? 0 : k == 4 ? 1 : k == 5 ? 16 : 17)
                   : (k <= 60) ? 10'(k == 57 ? 34 : k == 58 ? 35 : k == 59 ? 50 : 51)
                   : 10'(k == 1533 ? 1006 : k == 1534 ? 1007 : k == 1535 ? 1022 : 1023);
                ed = (k <= 6) ? ((k % 2) ? 8'hCC : 8'h33)
                   : (k <= 60) ? ((k % 2) ? 8'hFF : 8'h00)
                   : ((k % 2) ? 8'hC0 : 8'h03);
                n_cmp++;
                if ({we1, fa1, fd1} !== {1'b1, ea, ed}) begin
                    n_bad++;
                    $display("FAIL write_cycle%0d got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                             k, we1, fa1, fd1, ea, ed);
                end
            end
            if (k == 55) begin
                n_cmp++;
                if ({rd1, rd2} !== {12'hF09, 12'h001}) begin
                    n_bad++;
                    $display("FAIL src_addr_idx9 got=%h/%h exp=f09/001", rd1, rd2);
                end
            end
            if (k == 1537) begin
                n_cmp++;
                if ({fin1, busy1, we1} !== 3'b110) begin
                    n_bad++;
                    $display("FAIL done_cycle got fin=%b busy=%b we=%b exp 1 1 0", fin1, busy1, we1);
                end
            end
            if (k == 1538) begin
                n_cmp++;
                if ({fin1, busy1} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL idle_resume got fin=%b busy=%b exp 0 0", fin1, busy1);
                end
            end
        end
        n_cmp++;
        if (fcnt1 !== 1 || fcyc1 !== t0 + 1537) begin
            n_bad++;
            $display("FAIL finished_pulse got count=%0d cycle=%0d exp count=1 cycle=%0d", fcnt1, fcyc1, t0 + 1537);
        end
        n_cmp++;
        if (wcnt1 !== 1024 || dup1 !== 0) begin
            n_bad++;
            $display("FAIL write_count got=%0d dups=%0d exp=1024 dups=0", wcnt1, dup1);
        end
        n_cmp++;
        if (q1.size() !== 0 || q2.size() !== 0 || fcnt2 !== 1) begin
            n_bad++;
            $display("FAIL scoreboard_drain got q1=%0d q2=%0d fin2=%0d exp 0 0 1", q1.size(), q2.size(), fcnt2);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        clear_stats();
        foreach (ram[i]) ram[i] = 8'($urandom);
        push_frame(12'hF00, 1);
        push_frame(12'hFF8, 2);
        @(posedge clk); #1;
        start_signal = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 3078; k++) begin
            @(posedge clk); #1;
            start_signal = (k == 100) || (k == 1537) || (k == 1538);
            if (k == 1538) begin
                foreach (seen1[i]) seen1[i] = 1'b0;
                push_frame(12'hF00, 1);
                push_frame(12'hFF8, 2);
            end
            @(negedge clk); #1;
            if (k == 1538) begin
                n_cmp++;
                if (wcnt1 !== 1024 || fcnt1 !== 1 || busy1 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL no_restart got writes=%0d fins=%0d busy=%b exp 1024 1 0", wcnt1, fcnt1, busy1);
                end
            end
            if (k == 1539) begin
                n_cmp++;
                if (busy1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL restart_busy got=%b exp=1", busy1);
                end
            end
        end
        n_cmp++;
        if (wcnt1 !== 2048 || fcnt1 !== 2 || fcyc1 !== t0 + 1538 + 1537 || dup1 !== 0) begin
            n_bad++;
            $display("FAIL second_frame got writes=%0d fins=%0d fin_cycle=%0d dups=%0d exp 2048 2 %0d 0",
                     wcnt1, fcnt1, fcyc1, dup1, t0 + 3075);
        end
        n_cmp++;
        if (q1.size() !== 0 || q2.size() !== 0) begin
            n_bad++;
            $display("FAIL b2b_drain got q1=%0d q2=%0d exp 0 0", q1.size(), q2.size());
        end
    endtask

    task automatic test_reset_abort();
        int w_at;
        w_at = -1;
        clear_stats();
        push_frame(12'hF00, 1);
        push_frame(12'hFF8, 2);
        @(posedge clk); #1;
        start_signal = 1'b1;
        for (int k = 1; k <= 2600; k++) begin
            @(posedge clk); #1;
            start_signal = 1'b0;
            reset = (k != 500);
            if (k == 501) begin
                q1.delete();
                q2.delete();
            end
            @(negedge clk); #1;
            if (k == 501) begin
                w_at = wcnt1;
                n_cmp++;
                if ({we1, fin1, busy1, fa1, fd1, rd1, rd2} !==
                    {1'b0, 1'b0, 1'b0, 10'd0, 8'd0, 12'hF00, 12'hFF8}) begin
                    n_bad++;
                    $display("FAIL abort_state got we=%b fin=%b busy=%b addr=%0d data=%h src=%h/%h exp 0 0 0 0 00 f00/ff8",
                             we1, fin1, busy1, fa1, fd1, rd1, rd2);
                end
                n_cmp++;
                if (w_at !== 332) begin
                    n_bad++;
                    $display("FAIL abort_writes_before got=%0d exp=332", w_at);
                end
            end
        end
        n_cmp++;
        if (wcnt1 !== w_at || fcnt1 !== 0 || fcnt2 !== 0 || busy1 !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_quiet got writes=%0d fins=%0d/%0d busy=%b exp %0d 0/0 0",
                     wcnt1, fcnt1, fcnt2, busy1, w_at);
        end
    endtask

    initial begin
        foreach (ram[i]) ram[i] = 8'($urandom);
        test_reset();
        test_frame();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fb_upscale_renderer.md
Name: fb_upscale_renderer

Overview:
- Writer side of the LCD pixel framebuffer; the LCD controller is the reader.
- On a start pulse, copies the CHIP-8 64x32 1bpp display region from main RAM into the 128x64 1bpp framebuffer (1024 bytes, 16 bytes per row, MSB = leftmost pixel).
- Scales 2x horizontally and 2x vertically.
- Sits between the main RAM read port and the framebuffer write port; started by the periodic refresh tick.

Parameters:
- SRC_BASE, 12'hF00, main-RAM byte address of CHIP-8 display row 0, byte 0 (256 bytes, 8 bytes per row).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start_signal  in  1  one-cycle request to render one full frame
- main_ram_read_address  out  12  main RAM read address
- main_ram_out  in  8  main RAM read data, valid one cycle after the address (registered RAM)
- fb_write_address  out  10  framebuffer write address
- fb_write_enable  out  1  framebuffer write strobe
- fb_ram_in  out  8  framebuffer write data
- busy  out  1  high from FETCH through DONE
- finished_signal  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset (clk edge with reset=0):
  - state=IDLE, idx=0, data_reg=0.
  - fb_write_enable=0, finished_signal=0, busy=0, fb_write_address=0, fb_ram_in=0.
  - main_ram_read_address=SRC_BASE.
- Reset mid-frame aborts immediately. No further writes occur and finished_signal is not pulsed.
- idx is 8 bits and is the source byte index. y=idx[7:3] (0..31), xb=idx[2:0] (0..7).
- main_ram_read_address = SRC_BASE + idx, truncated to 12 bits. It is held constant across all states for that byte.
- States:
  - IDLE: start_signal=1 -> FETCH with idx=0. Otherwise stay.
  - FETCH: address presented -> LATCH.
  - LATCH: data_reg <= main_ram_out -> W0.
  - W0: fb_write_address = (2y)*16 + 2xb; fb_ram_in = dbl(data_reg[7:4]) -> W1.
  - W1: fb_write_address = (2y)*16 + 2xb + 1; fb_ram_in = dbl(data_reg[3:0]) -> W2.
  - W2: as W0 with row 2y+1 -> W3.
  - W3: as W1 with row 2y+1. If idx==255 -> DONE; else idx++ and -> FETCH.
  - DONE: finished_signal=1 -> IDLE.
- dbl(n) doubles each bit, MSB first: n3n3 n2n2 n1n1 n0n0.
- fb_write_enable=1 only in W0..W3. fb outputs are decoded from registered state and are stable for the whole cycle.
- Timing: with start high in cycle 0, FETCH is cycle 1 and the first write is cycle 3. Each byte takes 6 cycles. The last write is cycle 1536, finished_signal is high in cycle 1537, and IDLE resumes in cycle 1538.
- Exactly 1024 writes per frame, each framebuffer address written exactly once.
- start_signal is ignored in every state except IDLE, including DONE. No queuing.
- busy=1 in FETCH..DONE inclusive.
- Source address wraps modulo 4096 if SRC_BASE+255 overflows.

Decomposition:
- Package chip8_display_pkg:
  - CHIP8_W=64, CHIP8_H=32, SRC_BYTES=256, LCD_BYTES_PER_ROW=16, FB_BYTES=1024.
  - State enum {IDLE, FETCH, LATCH, W0, W1, W2, W3, DONE}.
- Sub-module nibble_doubler: 4-bit in, 8-bit out, combinational. Instantiated twice.

Test Plan:
- RAM[0xF00]=0xA5, start -> writes (0,0xCC), (1,0x33), (16,0xCC), (17,0x33) in cycles 3..6; busy rises in cycle 1.
- RAM[0xF09]=0xF0 -> writes (34,0xFF), (35,0x00), (50,0xFF), (51,0x00).
- RAM[0xFFF]=0x81 -> last four writes (1006,0xC0), (1007,0x03), (1022,0xC0), (1023,0x03); finished_signal high in cycle 1537 only; exactly 1024 fb_write_enable cycles with no duplicate addresses.
- start_signal pulsed in cycles 100 and 1537 -> no restart and write count stays 1024; a start in cycle 1538 begins a new frame.
- reset=0 in cycle 500 -> all outputs at reset values next cycle; no writes and no finished pulse afterwards until a new start.
- SRC_BASE=12'hFF8 -> source addresses wrap to 0x000..0x0F7 after 0xFFF.
